// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, command
// bytes, frame geometry and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_START   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_FRAME_EDGES = 11;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one open-drain PS/2 pin: 2-flop synchronizer, a glitch filter
// requiring FILTER_CYCLES equal samples, and a registered falling-edge pulse.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fe_o
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q, fe_q;
    logic          level_d, fe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the filtered level.
    always_comb begin
        level_d = level_q;
        fe_d    = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                level_d = sync2_q;
                fe_d    = level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Idle bus is released high, so the filter resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fe_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fe_q    <= fe_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// out data/parity/stop on device clock falls, check the ack, report status.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e    state_q, state_d;
    logic [IW-1:0] inh_q, inh_d, inh_inc_s;
    logic [TW-1:0] to_q, to_d, to_inc_s;
    logic [3:0]    n_q, n_d;
    logic [8:0]    frame_q, frame_d;
    logic          ok_q, ok_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          busy_q, busy_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic          clk_lvl_s, clk_fe_s, data_lvl_s, data_fe_unused;
    logic          timeout_s;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
        .clk(clk), .rst(rst), .pin_i(ps2_clk_in), .level_o(clk_lvl_s), .fe_o(clk_fe_s)
    );
    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
        .clk(clk), .rst(rst), .pin_i(ps2_data_in), .level_o(data_lvl_s), .fe_o(data_fe_unused)
    );

    // Both counters saturate rather than wrap.
    assign inh_inc_s = (inh_q == IW'(INHIBIT_CYCLES)) ? inh_q : inh_q + IW'(1);
    assign to_inc_s  = (to_q == TW'(TIMEOUT_CYCLES)) ? to_q : to_q + TW'(1);
    assign timeout_s = (to_q == TW'(TIMEOUT_CYCLES - 1));

    // Frame sequencing; output enables and status are computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        to_d      = to_q;
        n_d       = n_q;
        frame_d   = frame_q;
        ok_d      = ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                inh_d     = '0;
                to_d      = '0;
                if (tx_valid && ready_q) begin
                    frame_d  = {odd_parity(tx_data), tx_data};
                    state_d  = ST_INHIBIT;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    state_d   = ST_START;
                    data_oe_d = 1'b1;
                end else begin
                    inh_d = inh_inc_s;
                end
            end
            ST_START: begin
                state_d  = ST_SHIFT;
                clk_oe_d = 1'b0;
                n_d      = '0;
                to_d     = '0;
            end
            ST_SHIFT, ST_ACK: begin
                to_d = to_inc_s;
                if (timeout_s) begin
                    state_d   = ST_IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else if (clk_fe_s) begin
                    n_d = n_q + 4'd1;
                    if (state_q == ST_ACK) begin
                        // Device pulls data low before the final fall to acknowledge.
                        ok_d    = ~data_lvl_s;
                        state_d = ST_RELEASE;
                    end else if (n_q == 4'(PS2_FRAME_EDGES - 2)) begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end else begin
                        data_oe_d = ~frame_q[n_q];
                    end
                end else begin
                    n_d = n_q;
                end
            end
            ST_RELEASE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (clk_lvl_s && data_lvl_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            inh_q     <= '0;
            to_q      <= '0;
            n_q       <= '0;
            frame_q   <= '0;
            ok_q      <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            n_q       <= n_d;
            frame_q   <= frame_d;
            ok_q      <= ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard model;
// a scoreboard of expected results is checked by an independent monitor.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 4000;
    localparam int FLT = 4;
    localparam int H   = 50;
    localparam int M_ACK = 0, M_NACK = 1, M_GLITCH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_rel = 1'b1;
    logic       dev_data_rel = 1'b1;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = dev_clk_rel & ~ps2_clk_oe;
    assign ps2_data_in = dev_data_rel & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_CYCLES(FLT)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    typedef struct packed { logic [7:0] data; logic ok; logic frame; } exp_t;
    exp_t       exp_q[$];
    logic [9:0] cap_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;

    // Expected wire image: data LSB first, odd parity, stop bit.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every status pulse retires one scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (tx_done || tx_err)) begin
            if (tx_done) n_done++;
            if (tx_err) n_err++;
            check("done_err_exclusive", 32'(tx_done & tx_err), 32'd0);
            check("pulse_was_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result_done", 32'(tx_done), 32'(e.ok));
                check("result_err", 32'(tx_err), 32'(!e.ok));
                if (e.frame) begin
                    check("frame_captured", 32'(cap_q.size() > 0), 32'd1);
                    if (cap_q.size() > 0) check("frame_bits", 32'(cap_q.pop_front()), 32'(ref_frame(e.data)));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w = 0;
        while (tx_ready !== 1'b1 && w < 10000) begin @(negedge clk); w++; end
        check("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Returns on the first cycle with the host clock released.
    task automatic check_inhibit();
        int c = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && c < 1000) begin c++; @(negedge clk); end
        check("inhibit_len", 32'(c), 32'(INH));
        check("start_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("start_data_oe", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        check("shift_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("shift_data_oe", 32'(ps2_data_oe), 32'd1);
    endtask

    // Keyboard model: clocks 11 pulses, samples on rising edges, acks on edge 11.
    task automatic dev_run(input int mode, input int abort_at);
        logic [9:0] bits = 10'd0;
        int w = 0;
        while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < 3000) begin @(negedge clk); w++; end
        check("start_condition_seen", 32'(w < 3000), 32'd1);
        if (w < 3000) begin
            repeat (H) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
                dev_clk_rel = 1'b0;
                if (k == abort_at) return;
                repeat (H) @(negedge clk);
                dev_clk_rel = 1'b1;
                if (k <= 10) bits[k-1] = ps2_data_in;
                if (k == 10) begin
                    cap_q.push_back(bits);
                    if (mode != M_NACK) dev_data_rel = 1'b0;
                end
                if (k == 11) dev_data_rel = 1'b1;
                if (mode == M_GLITCH && k == 3) begin
                    repeat (H / 2) @(negedge clk);
                    dev_clk_rel = 1'b0;
                    repeat (2) @(negedge clk);
                    dev_clk_rel = 1'b1;
                    repeat (H / 2 - 2) @(negedge clk);
                end else begin
                    repeat (H) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 5000) begin @(negedge clk); w++; end
        check("busy_cleared", 32'(busy), 32'd0);
        check("ready_after_frame", 32'(tx_ready), 32'd1);
    endtask

    task automatic frame(input logic [7:0] b, input int mode, input bit inh_chk);
        int d0 = n_done;
        int e0 = n_err;
        exp_q.push_back('{data: b, ok: (mode != M_NACK), frame: 1'b1});
        send(b);
        if (inh_chk) check_inhibit();
        dev_run(mode, 0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("done_pulses", 32'(n_done - d0), (mode != M_NACK) ? 32'd1 : 32'd0);
        check("err_pulses", 32'(n_err - e0), (mode == M_NACK) ? 32'd1 : 32'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int k;
        int oe_seen;
        int d0, e0;
        logic [7:0] rb;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(tx_ready), 32'd1);

        frame(PS2_CMD_SET_LED, M_ACK, 1'b1);
        frame(8'h07, M_ACK, 1'b0);
        frame(8'h00, M_ACK, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            frame(rb, M_ACK, 1'b0);
        end
        rb = 8'($urandom_range(0, 255));
        frame(rb, M_NACK, 1'b0);
        frame(8'hA5, M_GLITCH, 1'b0);

        // Request while busy must be dropped.
        exp_q.push_back('{data: 8'h3C, ok: 1'b1, frame: 1'b1});
        send(8'h3C);
        repeat (3) @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_during_frame", 32'(busy), 32'd1);
        check("not_ready_during_frame", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        dev_run(M_ACK, 0);
        wait_idle();
        oe_seen = 0;
        repeat (300) begin @(negedge clk); if (ps2_clk_oe) oe_seen++; end
        check("no_second_frame", 32'(oe_seen), 32'd0);

        // Silent device: timeout.
        exp_q.push_back('{data: 8'h12, ok: 1'b0, frame: 1'b0});
        send(8'h12);
        check_inhibit();
        k = 0;
        while (tx_err !== 1'b1 && k < 6000) begin @(negedge clk); k++; end
        check("timeout_cycles", 32'(k), 32'(TO));
        check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
        @(negedge clk);
        check("timeout_ready", 32'(tx_ready), 32'd1);

        // Reset mid-frame at the fifth clock fall.
        d0 = n_done;
        e0 = n_err;
        send(PS2_CMD_RESET);
        dev_run(M_ACK, 5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("midrst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pulse", 32'(tx_done | tx_err), 32'd0);
        dev_clk_rel  = 1'b1;
        dev_data_rel = 1'b1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_no_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        frame(PS2_CMD_ENABLE, M_ACK, 1'b0);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("captures_consumed", 32'(cap_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
